sa_feeder: RTL

SA_FEEDER -- requirements
Module: sa_feeder

---
 rtl/sa_pkg.sv | 27 ++
 rtl/skew_delay.sv | 41 ++++
 rtl/sa_feeder.sv | 137 +++++++++++++
 3 files changed

// File: rtl/sa_pkg.sv
// ---------------------------------------------------------------------------
// sa_pkg
// Shared definitions for the systolic-array feeder: FSM state encoding,
// default geometry/width constants and the step-counter width helper.
// ---------------------------------------------------------------------------
package sa_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 8;
  localparam int unsigned DEF_NUM_ROW    = 16;
  localparam int unsigned DEF_NUM_COL    = 16;
  localparam int unsigned DEF_K_WIDTH    = 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FEED,
    S_DRAIN,
    S_DONE
  } state_t;

  // Step counter must reach (2**k_width - 1) + num_row + num_col - 2 without wrapping.
  function automatic int unsigned step_width(input int unsigned k_width,
                                             input int unsigned num_row,
                                             input int unsigned num_col);
    return k_width + $clog2(num_row + num_col) + 1;
  endfunction

endpackage

// File: rtl/skew_delay.sv
// ---------------------------------------------------------------------------
// skew_delay
// Enable-gated shift register used to skew one array edge lane.
// DEPTH = 0 degenerates to a plain wire.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   en       : advance strobe; stages shift only when high
//   d        : lane input
//   q        : lane input delayed by DEPTH enabled cycles
// ---------------------------------------------------------------------------
module skew_delay #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  if (DEPTH == 0) begin : g_wire
    logic unused;
    assign unused = ^{clk, rst, en};
    assign q      = d;
  end else begin : g_shift
    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int unsigned i = 0; i < DEPTH; i++) stage[i] <= '0;
      end else if (en) begin
        stage[0] <= d;
        for (int unsigned i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      end
    end

    assign q = stage[DEPTH-1];
  end

endmodule

// File: rtl/sa_feeder.sv
// ---------------------------------------------------------------------------
// sa_feeder
// Feeds a NUM_ROW x NUM_COL output-stationary systolic array. Accepts k_len
// beats (one A column + one B row each), skews them onto the array edges,
// drains the array with zero operands and pulses a per-PE capture strobe
// when each PE has accumulated its full dot product.
// Ports:
//   clk, rst       : clock, asynchronous active-high reset
//   start, k_len   : job request and its beat count (sampled together in IDLE)
//   in_valid/ready : beat handshake
//   a_data, b_data : A column (element r -> row r), B row (element c -> col c)
//   en             : array advance strobe
//   row_in, col_in : skewed left/top edge operands (zero when en is low)
//   clc            : per-PE result-capture pulse
//   busy, done     : job active (FEED/DRAIN), one-cycle completion pulse
// ---------------------------------------------------------------------------
module sa_feeder
  import sa_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned NUM_ROW    = DEF_NUM_ROW,
  parameter int unsigned NUM_COL    = DEF_NUM_COL,
  parameter int unsigned K_WIDTH    = DEF_K_WIDTH
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  input  logic [K_WIDTH-1:0]                  k_len,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [NUM_ROW:1][DATA_WIDTH-1:0]    a_data,
  input  logic [NUM_COL:1][DATA_WIDTH-1:0]    b_data,
  output logic                                en,
  output logic [NUM_ROW:1][DATA_WIDTH-1:0]    row_in,
  output logic [NUM_COL:1][DATA_WIDTH-1:0]    col_in,
  output logic [NUM_ROW:1][NUM_COL:1]         clc,
  output logic                                busy,
  output logic                                done
);

  localparam int unsigned STEP_W    = step_width(K_WIDTH, NUM_ROW, NUM_COL);
  localparam int unsigned SKEW_SPAN = NUM_ROW + NUM_COL - 2;

  state_t              state, state_next;
  logic [K_WIDTH-1:0]  k_reg;
  logic [STEP_W-1:0]   step;
  logic [STEP_W-1:0]   k_ext;
  logic [STEP_W-1:0]   feed_last;
  logic [STEP_W-1:0]   drain_last;
  logic                feeding;

  assign k_ext      = STEP_W'(k_reg);
  assign feed_last  = k_ext - STEP_W'(1);
  assign drain_last = k_ext + STEP_W'(SKEW_SPAN);
  assign feeding    = (state == S_FEED);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      k_reg <= '0;
      step  <= '0;
    end else begin
      state <= state_next;
      if (state == S_IDLE && start) begin
        k_reg <= k_len;
        step  <= '0;
      end else if (en) begin
        step <= step + STEP_W'(1);
      end
    end
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    en         = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) state_next = (k_len == '0) ? S_DONE : S_FEED;
      end
      S_FEED: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        en       = in_valid;
        if (in_valid && step == feed_last) state_next = S_DRAIN;
      end
      S_DRAIN: begin
        busy = 1'b1;
        en   = 1'b1;
        if (step == drain_last) state_next = S_DONE;
      end
      S_DONE: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Lane inputs are forced to zero outside FEED so DRAIN flushes zeros.
  for (genvar r = 1; r <= NUM_ROW; r++) begin : g_row
    logic [DATA_WIDTH-1:0] d, q;
    assign d = feeding ? a_data[r] : '0;
    skew_delay #(.WIDTH(DATA_WIDTH), .DEPTH(NUM_ROW - r)) u_skew (
      .clk (clk),
      .rst (rst),
      .en  (en),
      .d   (d),
      .q   (q)
    );
    assign row_in[r] = en ? q : '0;
  end

  for (genvar c = 1; c <= NUM_COL; c++) begin : g_col
    logic [DATA_WIDTH-1:0] d, q;
    assign d = feeding ? b_data[c] : '0;
    skew_delay #(.WIDTH(DATA_WIDTH), .DEPTH(NUM_COL - c)) u_skew (
      .clk (clk),
      .rst (rst),
      .en  (en),
      .d   (d),
      .q   (q)
    );
    assign col_in[c] = en ? q : '0;
  end

  // PE(r,c) sees its last operand pair at step offset+k_len-1; capture one step later.
  for (genvar r = 1; r <= NUM_ROW; r++) begin : g_clc_r
    for (genvar c = 1; c <= NUM_COL; c++) begin : g_clc_c
      localparam int unsigned OFFSET = (NUM_ROW - r) + (NUM_COL - c);
      assign clc[r][c] = en && (step == k_ext + STEP_W'(OFFSET));
    end
  end

endmodule
